// File: rtl/irq_pend4.sv
// rtl/irq_pend4.sv - 4-channel sticky request capture with masked priority pick and valid/ready output.
module irq_pend4 #(
    parameter bit EDGE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq,
    input  logic [3:0] mask,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_idx,
    output logic [3:0] pending
);

    logic [3:0] irq_q, irq_d;
    logic [3:0] pending_q, pending_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_idx_q, out_idx_d;

    logic [3:0] set_vec;
    logic [3:0] clr_vec;
    logic [3:0] cand;
    logic [1:0] winner;
    logic       acc;
    logic       load;

    always_comb begin
        irq_d = irq;

        if (EDGE) begin
            set_vec = irq & ~irq_q;
        end else begin
            set_vec = irq;
        end

        acc     = out_valid_q & out_ready;
        clr_vec = acc ? (4'b0001 << out_idx_q) : 4'b0000;

        // A fresh event on the bit being accepted survives the clear.
        pending_d = (pending_q & ~clr_vec) | set_vec;
        cand      = pending_d & mask;

        if (cand[3]) begin
            winner = 2'd3;
        end else if (cand[2]) begin
            winner = 2'd2;
        end else if (cand[1]) begin
            winner = 2'd1;
        end else begin
            winner = 2'd0;
        end

        // The presented index is frozen until the consumer takes it.
        load        = ~out_valid_q | acc;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = |cand;
            out_idx_d   = winner;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q       <= 4'b0000;
            pending_q   <= 4'b0000;
            out_valid_q <= 1'b0;
            out_idx_q   <= 2'd0;
        end else begin
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_pend4.sv
// tb/tb_irq_pend4.sv - vector table and scoreboard bench for irq_pend4 (edge and level instances).
module tb_irq_pend4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_e, mask_e, irq_l, mask_l;
    logic       rdy_e, rdy_l;
    logic       val_e, val_l;
    logic [1:0] idx_e, idx_l;
    logic [3:0] pend_e, pend_l;

    irq_pend4 #(.EDGE(1'b1)) dut_e (
        .clk(clk), .rst(rst), .irq(irq_e), .mask(mask_e),
        .out_valid(val_e), .out_ready(rdy_e), .out_idx(idx_e), .pending(pend_e)
    );

    irq_pend4 #(.EDGE(1'b0)) dut_l (
        .clk(clk), .rst(rst), .irq(irq_l), .mask(mask_l),
        .out_valid(val_l), .out_ready(rdy_l), .out_idx(idx_l), .pending(pend_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] irq;
        logic [3:0] mask;
        logic       rdy;
        logic [3:0] pend;
        logic       v;
        logic [1:0] idx;
    } vec_t;

    typedef struct {
        logic [3:0] pend;
        logic       v;
        logic [1:0] idx;
        int         tag;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add_vec(input logic [3:0] i, input logic [3:0] m, input logic r,
                           input logic [3:0] p, input logic v, input logic [1:0] x);
        vec_t t;
        t.irq = i; t.mask = m; t.rdy = r; t.pend = p; t.v = v; t.idx = x;
        vecs.push_back(t);
    endtask

    task automatic push_exp(input logic [3:0] p, input logic v, input logic [1:0] x, input int tag);
        exp_t e;
        e.pend = p; e.v = v; e.idx = x; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic check_pop(input string nm, input logic [3:0] p, input logic v, input logic [1:0] x);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s: no expected entry queued", nm);
            return;
        end
        e = sb.pop_front();
        if (p !== e.pend || v !== e.v || x !== e.idx) begin
            n_bad++;
            $display("FAIL %s[%0d]: got pending=%b valid=%b idx=%0d, want pending=%b valid=%b idx=%0d",
                     nm, e.tag, p, v, x, e.pend, e.v, e.idx);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        irq_e = 4'h0; mask_e = 4'hF; rdy_e = 1'b0;
        irq_l = 4'h0; mask_l = 4'h0; rdy_l = 1'b0;

        // irq, mask, ready -> pending, valid, idx after the edge
        add_vec(4'b0000, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0100, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
        for (int k = 0; k < 5; k++)
            add_vec(4'b0000, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b1011, 4'hF, 1'b0, 4'b1011, 1'b1, 2'd3);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0011, 1'b1, 2'd1);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0010, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b1000, 4'hF, 1'b0, 4'b1010, 1'b1, 2'd1);
        add_vec(4'b0000, 4'hF, 1'b0, 4'b1010, 1'b1, 2'd1);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b1001, 4'b0111, 1'b0, 4'b1001, 1'b1, 2'd0);
        add_vec(4'b0000, 4'b0111, 1'b1, 4'b1000, 1'b0, 2'd0);
        add_vec(4'b0000, 4'hF, 1'b0, 4'b1000, 1'b1, 2'd3);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0100, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b0000, 4'hF, 1'b0, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b0100, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0001, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0);
        add_vec(4'b0001, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0);
        add_vec(4'b0010, 4'hF, 1'b0, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b0000, 4'h0, 1'b0, 4'b0010, 1'b1, 2'd1);
        add_vec(4'b0000, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0);

        repeat (2) @(posedge clk);
        #1;
        push_exp(4'b0000, 1'b0, 2'd0, -1);
        check_pop("reset_edge_dut", pend_e, val_e, idx_e);
        push_exp(4'b0000, 1'b0, 2'd0, -1);
        check_pop("reset_level_dut", pend_l, val_l, idx_l);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[n]) begin
            @(negedge clk);
            irq_e = vecs[n].irq; mask_e = vecs[n].mask; rdy_e = vecs[n].rdy;
            push_exp(vecs[n].pend, vecs[n].v, vecs[n].idx, n);
            @(posedge clk);
            #1;
            check_pop("vec", pend_e, val_e, idx_e);
        end

        // irq already high as reset releases counts as an edge
        @(negedge clk);
        rst = 1'b1; irq_e = 4'b0100; mask_e = 4'hF; rdy_e = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_exp(4'b0100, 1'b1, 2'd2, 100);
        @(posedge clk);
        #1;
        check_pop("first_cycle_edge", pend_e, val_e, idx_e);
        @(negedge clk);
        irq_e = 4'b0000; rdy_e = 1'b1;
        push_exp(4'b0000, 1'b0, 2'd0, 101);
        @(posedge clk);
        #1;
        check_pop("first_cycle_drain", pend_e, val_e, idx_e);

        // level mode: held request re-presents after every accept
        @(negedge clk);
        irq_l = 4'b0010; mask_l = 4'hF; rdy_l = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_exp(4'b0010, 1'b1, 2'd1, 200 + k);
            @(posedge clk);
            #1;
            check_pop("level_hold", pend_l, val_l, idx_l);
        end
        #2;
        rst = 1'b1;
        #1;
        push_exp(4'b0000, 1'b0, 2'd0, 300);
        check_pop("async_reset_level", pend_l, val_l, idx_l);
        push_exp(4'b0000, 1'b0, 2'd0, 301);
        check_pop("async_reset_edge", pend_e, val_e, idx_e);
        @(negedge clk);
        rst = 1'b0;

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_pend4.md
Name: irq_pend4

Overview:
- 4-channel request capture and arbitration stage; sits directly upstream of the 4-input priority index logic (channel 3 highest).
- Captures request events into sticky pending bits, applies an enable mask, and presents the winning channel index over a valid/ready handshake.
- Clears the winning pending bit on acceptance, so the consumer (controller or sequencer) services each event exactly once.

Parameters:
- EDGE, 1, 1 = capture on rising edge of irq[i]; 0 = level capture (pending re-set every cycle irq[i] is high).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq  input  4  raw request lines, synchronous to clk; irq[3] highest priority.
- mask  input  4  per-channel enable; 1 = channel may win arbitration.
- out_valid  output  1  out_idx holds a valid winning channel.
- out_ready  input  1  consumer accepts out_idx when out_valid and out_ready are both 1 at a clk edge.
- out_idx  output  2  encoded winning channel, 3..0.
- pending  output  4  current sticky pending register, for status readback.

Behaviour:
- Reset: all state clears asynchronously while rst = 1.
  - pending = 4'b0000; irq_q (previous irq sample) = 4'b0000; out_valid = 0; out_idx = 2'd0.
- Set vector:
  - EDGE = 1: set = irq & ~irq_q.
  - EDGE = 0: set = irq.
  - irq_q <= irq every cycle.
  - If irq is already high when reset deasserts, that counts as an edge on the first cycle.
- Accept: acc = out_valid & out_ready.
  - clr = one-hot(out_idx) when acc = 1, else 0.
- Pending update: pend_nxt = (pending & ~clr) | set.
  - If set and clr hit the same bit in one cycle, set wins and the bit stays pending (new event).
- Candidate vector: cand = pend_nxt & mask.
  - Winner is the highest set index of cand: 3 > 2 > 1 > 0.
- Output register load: when (out_valid == 0) or acc.
  - out_valid <= |cand.
  - out_idx <= winner, or 2'd0 if cand == 0.
- Hold rule: while out_valid = 1 and out_ready = 0:
  - out_idx and out_valid hold stable. No retraction, no re-prioritisation.
  - This holds even if a higher-priority request arrives or mask clears the presented channel.
- Latency:
  - irq rising edge at cycle n (sampled at edge n) → pending bit set and, if the output is idle, out_valid = 1 after the same edge.
  - The output is visible in cycle n+1.
- Back-to-back:
  - Accept at edge k clears the presented bit.
  - The next winner, computed from pend_nxt, is presented in the cycle after edge k with no bubble.
- Masking:
  - Masked channels keep accumulating pending bits.
  - Unmasking makes a masked pending channel eligible at the next load opportunity.
- Multiple events on one channel before acceptance collapse into a single pending bit; there is no counting.
- EDGE = 0: an accepted channel whose irq is still high re-sets immediately and re-presents.
  - This is the intended level semantics.
- All-zero cand with out_valid = 0: out_valid stays 0 and out_idx = 2'd0.
- out_ready while out_valid = 0 has no effect.
- Reset mid-handshake: pending and output are cleared immediately (asynchronous). No accept occurs on that edge.

Test Plan:
- Reset, then irq pulses 4'b0100 for 1 cycle, out_ready = 0 → pending = 4'b0100, out_valid = 1, out_idx = 2 one cycle later; outputs hold for 5 cycles.
- pending = 4'b1011, mask = 4'hF, out_ready = 1 continuously → out_idx sequence 3, 1, 0 on consecutive cycles, then out_valid = 0 and pending = 4'b0000.
- out_idx = 1 presented and stalled, then irq[3] pulses → out_idx stays 1 until out_ready = 1; next presented out_idx = 3.
- mask = 4'b0111, irq[3] and irq[0] pulse together → out_idx = 0 presented and accepted; pending = 4'b1000, out_valid = 0. Then mask = 4'hF → out_valid = 1, out_idx = 3.
- Accept of channel 2 in the same cycle as a new irq[2] rising edge → pending[2] remains 1 and out_idx = 2 is re-presented next cycle.
- EDGE = 0: irq[1] held high, out_ready = 1 → out_idx = 1 presented every cycle. Then rst asserted mid-stream → out_valid = 0 and pending = 0 immediately, without waiting for clk.
